// File: rtl/known_ch_table.sv
// Table of up to NUM_ENTRIES cluster-head advertisements with heartbeat aging,
// worst-entry eviction and a registered best-CH publication stage.
module known_ch_table #(
   parameter int WORD_WIDTH  = 16,
   parameter int NUM_ENTRIES = 8,
   parameter int AGE_WIDTH   = 4,
   parameter int MAX_AGE     = 10
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               en_KCH,
   input  logic                               HB_reset,
   input  logic                               hb_tick,
   input  logic [WORD_WIDTH-1:0]              HB_CHlimit,
   input  logic [WORD_WIDTH-1:0]              fCH_ID,
   input  logic [WORD_WIDTH-1:0]              fCH_Hops,
   input  logic [WORD_WIDTH-1:0]              fCH_QValue,
   output logic [WORD_WIDTH-1:0]              chosenCH,
   output logic [WORD_WIDTH-1:0]              hopsfromCH,
   output logic                               ch_valid,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   ch_count,
   output logic                               adv_drop
);

   localparam int CW = $clog2(NUM_ENTRIES + 1);
   localparam int IW = $clog2(NUM_ENTRIES);
   localparam logic [WORD_WIDTH-1:0] UNREACH = '1;

   logic [NUM_ENTRIES-1:0] valid_p0;
   logic [WORD_WIDTH-1:0]  id_p0   [NUM_ENTRIES];
   logic [WORD_WIDTH-1:0]  hops_p0 [NUM_ENTRIES];
   logic [WORD_WIDTH-1:0]  q_p0    [NUM_ENTRIES];
   logic [AGE_WIDTH-1:0]   age_p0  [NUM_ENTRIES];

   logic [WORD_WIDTH-1:0] lim;
   logic [CW-1:0]         cnt;
   logic                  hit, free, worst_found, best_found;
   logic [IW-1:0]         hit_idx, free_idx, worst_idx, best_idx;
   logic [WORD_WIDTH-1:0] wq, wh, bq, bh, bid;
   logic                  adv_ok, wr_en, drop;
   logic [IW-1:0]         wr_idx;
   logic                  drop_p1;

   function automatic logic [AGE_WIDTH-1:0] age_inc(input logic [AGE_WIDTH-1:0] a);
      if (a >= AGE_WIDTH'(MAX_AGE))
         return AGE_WIDTH'(MAX_AGE);
      return a + 1'b1;
   endfunction

   // Ranking shared by selection and eviction: higher Q wins, then fewer hops.
   function automatic logic better(input logic [WORD_WIDTH-1:0] qa, input logic [WORD_WIDTH-1:0] ha,
                                   input logic [WORD_WIDTH-1:0] qb, input logic [WORD_WIDTH-1:0] hb);
      return (qa > qb) || ((qa == qb) && (ha < hb));
   endfunction

   // Stage p0: table lookup, placement decision and best-entry search
   always_comb begin
      lim         = (HB_CHlimit > WORD_WIDTH'(NUM_ENTRIES)) ? WORD_WIDTH'(NUM_ENTRIES) : HB_CHlimit;
      cnt         = '0;
      hit         = 1'b0;
      hit_idx     = '0;
      free        = 1'b0;
      free_idx    = '0;
      worst_found = 1'b0;
      worst_idx   = '0;
      wq          = '0;
      wh          = '0;
      best_found  = 1'b0;
      best_idx    = '0;
      bq          = '0;
      bh          = '0;
      bid         = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         cnt = cnt + CW'(valid_p0[i]);
         if (valid_p0[i] && (id_p0[i] == fCH_ID) && !hit) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
         if (!valid_p0[i] && !free) begin
            free     = 1'b1;
            free_idx = IW'(i);
         end
         // Not-better-than keeps the highest index on a full tie.
         if (valid_p0[i] && (!worst_found || !better(q_p0[i], hops_p0[i], wq, wh))) begin
            worst_found = 1'b1;
            worst_idx   = IW'(i);
            wq          = q_p0[i];
            wh          = hops_p0[i];
         end
         // Strictly-better keeps the lowest index on a full tie.
         if (valid_p0[i] && (!best_found || better(q_p0[i], hops_p0[i], bq, bh))) begin
            best_found = 1'b1;
            best_idx   = IW'(i);
            bq         = q_p0[i];
            bh         = hops_p0[i];
            bid        = id_p0[i];
         end
      end

      adv_ok = en_KCH && !HB_reset && (fCH_Hops != UNREACH);
      wr_en  = 1'b0;
      wr_idx = '0;
      if (adv_ok) begin
         if (hit) begin
            wr_en  = 1'b1;
            wr_idx = hit_idx;
         end else if (lim != '0) begin
            if (WORD_WIDTH'(cnt) < lim) begin
               wr_en  = free;
               wr_idx = free_idx;
            end else if (worst_found && better(fCH_QValue, fCH_Hops, wq, wh)) begin
               wr_en  = 1'b1;
               wr_idx = worst_idx;
            end
         end
      end
      drop = en_KCH && !HB_reset && !wr_en;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         valid_p0 <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++)
            age_p0[i] <= '0;
      end else if (HB_reset) begin
         valid_p0 <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++)
            age_p0[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (wr_en && (wr_idx == IW'(i))) begin
               valid_p0[i] <= 1'b1;
               age_p0[i]   <= '0;
            end else if (hb_tick && valid_p0[i]) begin
               age_p0[i] <= age_inc(age_p0[i]);
               if (age_inc(age_p0[i]) == AGE_WIDTH'(MAX_AGE))
                  valid_p0[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (wr_en && (wr_idx == IW'(i))) begin
            id_p0[i]   <= fCH_ID;
            hops_p0[i] <= fCH_Hops;
            q_p0[i]    <= fCH_QValue;
         end
      end
   end

   // Stage p1: drop flag aligned with the table write edge
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         drop_p1 <= 1'b0;
      else
         drop_p1 <= drop;
   end

   // Stage p2: published outputs, one edge after the table
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         chosenCH   <= '0;
         hopsfromCH <= '1;
         ch_valid   <= 1'b0;
         ch_count   <= '0;
         adv_drop   <= 1'b0;
      end else begin
         if (best_found)
            chosenCH <= bid;
         hopsfromCH <= best_found ? bh : UNREACH;
         ch_valid   <= best_found;
         ch_count   <= cnt;
         adv_drop   <= drop_p1;
      end
   end

   logic unused_best_idx;
   assign unused_best_idx = ^best_idx;

endmodule

// File: tb/tb_known_ch_table.sv
// Scoreboard bench for known_ch_table: expected outputs are queued at drive time
// and compared when the registered outputs for that cycle appear.
module tb_known_ch_table;

   localparam int W  = 16;
   localparam int N  = 8;
   localparam int AW = 4;
   localparam int MA = 3;
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          en_KCH = 1'b0;
   logic          HB_reset = 1'b0;
   logic          hb_tick = 1'b0;
   logic [W-1:0]  HB_CHlimit = 16'd8;
   logic [W-1:0]  fCH_ID = '0;
   logic [W-1:0]  fCH_Hops = '0;
   logic [W-1:0]  fCH_QValue = '0;
   logic [W-1:0]  chosenCH;
   logic [W-1:0]  hopsfromCH;
   logic          ch_valid;
   logic [CW-1:0] ch_count;
   logic          adv_drop;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int            due;
      logic [W-1:0]  chosen;
      logic [W-1:0]  hops;
      logic          v;
      logic [CW-1:0] cnt;
      logic          drop;
   } exp_t;

   exp_t  sb[$];
   string sb_tag[$];

   known_ch_table #(.WORD_WIDTH(W), .NUM_ENTRIES(N), .AGE_WIDTH(AW), .MAX_AGE(MA)) dut (
      .clk(clk), .nrst(nrst), .en_KCH(en_KCH), .HB_reset(HB_reset), .hb_tick(hb_tick),
      .HB_CHlimit(HB_CHlimit), .fCH_ID(fCH_ID), .fCH_Hops(fCH_Hops), .fCH_QValue(fCH_QValue),
      .chosenCH(chosenCH), .hopsfromCH(hopsfromCH), .ch_valid(ch_valid),
      .ch_count(ch_count), .adv_drop(adv_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive one cycle of stimulus and queue the outputs it must produce two edges later.
   task automatic step(input string tag, input logic en, input logic hbr, input logic tick,
                       input logic [W-1:0] id, input logic [W-1:0] hp, input logic [W-1:0] qv,
                       input logic [W-1:0] e_ch, input logic [W-1:0] e_hp, input logic e_v,
                       input logic [CW-1:0] e_cnt, input logic e_drop);
      exp_t e;
      e.due    = cyc + 2;
      e.chosen = e_ch;
      e.hops   = e_hp;
      e.v      = e_v;
      e.cnt    = e_cnt;
      e.drop   = e_drop;
      sb.push_back(e);
      sb_tag.push_back(tag);
      en_KCH     = en;
      HB_reset   = hbr;
      hb_tick    = tick;
      fCH_ID     = id;
      fCH_Hops   = hp;
      fCH_QValue = qv;
      @(posedge clk);
      #1;
      en_KCH   = 1'b0;
      HB_reset = 1'b0;
      hb_tick  = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t  e;
      string t;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         t = sb_tag.pop_front();
         check({t, ".chosen"}, 32'(chosenCH), 32'(e.chosen));
         check({t, ".hops"},   32'(hopsfromCH), 32'(e.hops));
         check({t, ".valid"},  32'(ch_valid), 32'(e.v));
         check({t, ".count"},  32'(ch_count), 32'(e.cnt));
         check({t, ".drop"},   32'(adv_drop), 32'(e.drop));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst.chosen", 32'(chosenCH), 32'h0);
      check("rst.hops",   32'(hopsfromCH), 32'hFFFF);
      check("rst.valid",  32'(ch_valid), 32'h0);
      check("rst.count",  32'(ch_count), 32'h0);
      check("rst.drop",   32'(adv_drop), 32'h0);
      nrst = 1'b1;
      @(posedge clk);
      #1;

      HB_CHlimit = 16'd8;
      step("adv5",   1, 0, 0,  5,  2, 100,  5,  2, 1, 1, 0);
      step("adv9",   1, 0, 0,  9,  1, 100,  9,  1, 1, 2, 0);
      step("upd5",   1, 0, 0,  5,  3, 200,  5,  3, 1, 2, 0);
      HB_CHlimit = 16'd2;
      step("rej7",   1, 0, 0,  7,  4,  50,  5,  3, 1, 2, 1);
      step("idle_a", 0, 0, 0,  0,  0,   0,  5,  3, 1, 2, 0);
      step("rep9",   1, 0, 0,  7,  4, 150,  5,  3, 1, 2, 0);
      step("gone9",  1, 0, 0,  9,  1, 100,  5,  3, 1, 2, 1);
      step("low5",   1, 0, 0,  5,  3,  10,  7,  4, 1, 2, 0);
      step("tick1",  0, 0, 1,  0,  0,   0,  7,  4, 1, 2, 0);
      step("tick2",  0, 0, 1,  0,  0,   0,  7,  4, 1, 2, 0);
      step("tick3r", 1, 0, 1,  5,  3,  10,  5,  3, 1, 1, 0);
      step("tick4",  0, 0, 1,  0,  0,   0,  5,  3, 1, 1, 0);
      step("tick5",  0, 0, 1,  0,  0,   0,  5,  3, 1, 1, 0);
      step("tick6",  0, 0, 1,  0,  0,   0,  5, 16'hFFFF, 0, 0, 0);
      HB_CHlimit = 16'd8;
      step("adv3",   1, 0, 0,  3,  1,  40,  3,  1, 1, 1, 0);
      step("hbr",    1, 1, 0,  4,  1, 500,  3, 16'hFFFF, 0, 0, 0);
      step("unrch",  1, 0, 0,  6, 16'hFFFF, 900, 3, 16'hFFFF, 0, 0, 1);
      HB_CHlimit = 16'd0;
      step("lim0",   1, 0, 0,  8,  1,   5,  3, 16'hFFFF, 0, 0, 1);
      HB_CHlimit = 16'h0100;
      step("adv2",   1, 0, 0,  2,  5,  60,  2,  5, 1, 1, 0);
      step("clamp",  1, 0, 0, 12,  9,  61, 12,  9, 1, 2, 0);

      repeat (2) @(posedge clk);
      #3;
      nrst = 1'b0;
      #1;
      check("arst.chosen", 32'(chosenCH), 32'h0);
      check("arst.hops",   32'(hopsfromCH), 32'hFFFF);
      check("arst.valid",  32'(ch_valid), 32'h0);
      check("arst.count",  32'(ch_count), 32'h0);
      check("arst.drop",   32'(adv_drop), 32'h0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if (sb.size() != 0)
         check("sb_drain", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
